// File: rtl/sdpram_pkg.sv
// ---------------------------------------------------------------------------
// sdpram_pkg
//   Shared types and helpers for the byte-enabled simple dual-port RAM.
//   - sweep_state_t : state of the clear-on-reset sweep controller.
//   - nbytes()      : number of byte lanes in a data word.
//   - params_ok()   : parameter legality test. The top module calls it at
//                     elaboration so that an illegal configuration stops
//                     the build instead of producing a broken RAM.
// ---------------------------------------------------------------------------
package sdpram_pkg;

  // IDLE  : normal user operation.
  // CLEAR : the memory is being overwritten with INIT_VALUE.
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } sweep_state_t;

  // Byte lanes per word. Callers must pass a multiple of 8.
  function automatic int nbytes(input int data_width);
    return data_width / 8;
  endfunction

  // Legal configurations:
  //   data width is a non-zero multiple of 8,
  //   read latency is 1 or 2 cycles.
  function automatic bit params_ok(input int data_width,
                                   input int read_latency);
    bit width_ok;
    bit latency_ok;
    width_ok   = (data_width > 0) && ((data_width % 8) == 0);
    latency_ok = (read_latency == 1) || (read_latency == 2);
    return width_ok && latency_ok;
  endfunction

endpackage

// File: rtl/sdpram_clear_ctrl.sv
// ---------------------------------------------------------------------------
// sdpram_clear_ctrl
//   Sweep controller that clears the RAM after reset. Once rst_n is released
//   it issues one full-word write per cycle to addresses 0 .. depth-1. It
//   then drops init_busy and stays in IDLE until the next reset. If reset
//   arrives during a sweep, the sweep starts again from address 0.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   clear_we   out  write strobe for the sweep (registered)
//   clear_addr out  address written by the sweep this cycle (registered)
//   init_busy  out  high while the sweep owns the write port (registered)
// ---------------------------------------------------------------------------
module sdpram_clear_ctrl
  import sdpram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 10,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  clear_we,
  output logic [ADDR_WIDTH-1:0] clear_addr,
  output logic                  init_busy
);

  // The counter is one bit wider than the address. The terminal compare is
  // against depth-1, so the counter can never silently alias back to 0.
  localparam logic [ADDR_WIDTH:0] LAST_ADDR = {1'b0, {ADDR_WIDTH{1'b1}}};

  sweep_state_t          state_q;
  logic [ADDR_WIDTH:0]   cnt_q;
  logic                  busy_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      if (CLEAR_ON_RESET) begin
        state_q <= CLEAR;
        busy_q  <= 1'b1;
      end else begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end
    end else begin
      case (state_q)
        CLEAR: begin
          // The write to cnt_q happens in this same cycle through clear_we.
          // After the write to the last address, the controller returns the
          // port to the user.
          if (cnt_q == LAST_ADDR) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
          end
        end
        default: begin
          // IDLE has no exit. Only reset starts a new sweep.
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // busy_q is high for exactly the cycles in which state_q is CLEAR.
  // Every one of those cycles writes one word.
  assign clear_we   = busy_q;
  assign clear_addr = cnt_q[ADDR_WIDTH-1:0];
  assign init_busy  = busy_q;

endmodule

// File: rtl/sdpram_be.sv
// ---------------------------------------------------------------------------
// sdpram_be
//   Simple dual-port RAM on a single clock:
//     - one write port with per-byte enables,
//     - one read port with a latency of 1 or 2 cycles,
//     - optional write-to-read forwarding on a same-address collision,
//     - optional hardware sweep that sets every word to INIT_VALUE after
//       reset.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   synchronous active-low reset
//   write_addr   in   write word address
//   write_data   in   write data
//   write_enable in   write strobe
//   byte_enable  in   per-byte write mask; bit i covers data[8i+7:8i]
//   read_addr    in   read word address
//   read_enable  in   read strobe
//   read_data    out  read result; held until the next valid read
//   read_valid   out  one-cycle pulse; read_data belongs to that read
//   init_busy    out  high while the clear sweep runs; user port ignored
// ---------------------------------------------------------------------------
module sdpram_be
  import sdpram_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 10,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    READ_LATENCY   = 2,
  parameter bit                    FORWARD        = 1'b1,
  parameter bit                    CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '0,
  localparam int                   NBYTES         = nbytes(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  write_enable,
  input  logic [NBYTES-1:0]     byte_enable,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  input  logic                  read_enable,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid,
  output logic                  init_busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if (!params_ok(DATA_WIDTH, READ_LATENCY)) begin : g_param_check
    $error("sdpram_be: DATA_WIDTH must be a multiple of 8 and READ_LATENCY must be 1 or 2");
  end

  // -------------------------------------------------------------------------
  // Clear sweep controller
  // -------------------------------------------------------------------------
  logic                  clear_we;
  logic [ADDR_WIDTH-1:0] clear_addr;

  sdpram_clear_ctrl #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_we   (clear_we),
    .clear_addr (clear_addr),
    .init_busy  (init_busy)
  );

  // While the sweep runs, the user port is ignored completely.
  logic user_we;
  logic user_re;

  assign user_we = write_enable & ~init_busy;
  assign user_re = read_enable  & ~init_busy;

  // -------------------------------------------------------------------------
  // Write port mux: sweep or user
  // -------------------------------------------------------------------------
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [NBYTES-1:0]     wr_be;

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = write_addr;
    wr_data = write_data;
    wr_be   = byte_enable;
    // Nothing commits to the array while reset is held. The memory keeps
    // its contents until the sweep, or the user, overwrites them.
    if (rst_n) begin
      if (init_busy) begin
        wr_en   = clear_we;
        wr_addr = clear_addr;
        wr_data = INIT_VALUE;
        wr_be   = '1;
      end else begin
        wr_en   = user_we;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Storage
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (wr_be[i]) begin
          mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read stage 1: registered array read plus collision capture
  // -------------------------------------------------------------------------
  // The array read returns the pre-write word (read-before-write). When
  // forwarding is enabled, the colliding write's data and byte mask are
  // registered next to it. The merge is then done from registers. This
  // keeps the array read a plain registered read.
  logic                  collide;
  logic [DATA_WIDTH-1:0] rd_word_q;
  logic [DATA_WIDTH-1:0] fwd_data_q;
  logic [NBYTES-1:0]     fwd_mask_q;
  logic [NBYTES-1:0]     fwd_mask_d;
  logic                  valid1_q;
  logic [DATA_WIDTH-1:0] rd_merged;

  assign collide    = FORWARD && user_we && user_re && (write_addr == read_addr);
  assign fwd_mask_d = collide ? byte_enable : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_word_q  <= '0;
      fwd_data_q <= '0;
      fwd_mask_q <= '0;
      valid1_q   <= 1'b0;
    end else begin
      valid1_q <= user_re;
      // All stage-1 registers hold while no read is captured. This is what
      // makes read_data hold its value between reads.
      if (user_re) begin
        rd_word_q  <= mem[read_addr];
        fwd_data_q <= write_data;
        fwd_mask_q <= fwd_mask_d;
      end
    end
  end

  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_merge
    assign rd_merged[8*gi +: 8] = fwd_mask_q[gi] ? fwd_data_q[8*gi +: 8]
                                                 : rd_word_q[8*gi +: 8];
  end

  // -------------------------------------------------------------------------
  // Output latency
  // -------------------------------------------------------------------------
  if (READ_LATENCY == 1) begin : g_lat1
    assign read_data  = rd_merged;
    assign read_valid = valid1_q;
  end else begin : g_lat2
    logic [DATA_WIDTH-1:0] read_data_q;
    logic                  valid2_q;

    // The second register samples only stage-1 registers. A write that
    // arrives after the capture edge therefore cannot reach this result.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        read_data_q <= '0;
        valid2_q    <= 1'b0;
      end else begin
        valid2_q <= valid1_q;
        if (valid1_q) begin
          read_data_q <= rd_merged;
        end
      end
    end

    assign read_data  = read_data_q;
    assign read_valid = valid2_q;
  end

endmodule

// File: tb/tb_sdpram_be.sv
// ---------------------------------------------------------------------------
// tb_sdpram_be
//   Directed bench. It drives three configurations of sdpram_be side by side:
//     A : ADDR_WIDTH=4, DATA_WIDTH=32, READ_LATENCY=2, FORWARD=1,
//         INIT_VALUE=A5A5A5A5
//     B : ADDR_WIDTH=4, DATA_WIDTH=32, READ_LATENCY=1, FORWARD=0,
//         INIT_VALUE=0
//     C : ADDR_WIDTH=8, DATA_WIDTH=16, READ_LATENCY=1, FORWARD=1,
//         INIT_VALUE=0
// ---------------------------------------------------------------------------
module tb_sdpram_be;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        we [3];
  logic [7:0]  wa [3];
  logic [31:0] wd [3];
  logic [3:0]  be [3];
  logic        re [3];
  logic [7:0]  ra [3];

  logic [31:0] rd_a, rd_b;
  logic [15:0] rd_c;
  logic        rv_a, rv_b, rv_c;
  logic        busy_a, busy_b, busy_c;

  int lat [3] = '{2, 1, 1};
  int passed = 0;
  int total  = 0;

  sdpram_be #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .READ_LATENCY(2), .FORWARD(1'b1),
              .CLEAR_ON_RESET(1'b1), .INIT_VALUE(32'hA5A5A5A5)) u_a (
    .clk(clk), .rst_n(rst_n),
    .write_addr(wa[0][3:0]), .write_data(wd[0]), .write_enable(we[0]), .byte_enable(be[0]),
    .read_addr(ra[0][3:0]), .read_enable(re[0]),
    .read_data(rd_a), .read_valid(rv_a), .init_busy(busy_a));

  sdpram_be #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .READ_LATENCY(1), .FORWARD(1'b0),
              .CLEAR_ON_RESET(1'b1), .INIT_VALUE(32'h0)) u_b (
    .clk(clk), .rst_n(rst_n),
    .write_addr(wa[1][3:0]), .write_data(wd[1]), .write_enable(we[1]), .byte_enable(be[1]),
    .read_addr(ra[1][3:0]), .read_enable(re[1]),
    .read_data(rd_b), .read_valid(rv_b), .init_busy(busy_b));

  sdpram_be #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .READ_LATENCY(1), .FORWARD(1'b1),
              .CLEAR_ON_RESET(1'b1), .INIT_VALUE(16'h0)) u_c (
    .clk(clk), .rst_n(rst_n),
    .write_addr(wa[2]), .write_data(wd[2][15:0]), .write_enable(we[2]), .byte_enable(be[2][1:0]),
    .read_addr(ra[2]), .read_enable(re[2]),
    .read_data(rd_c), .read_valid(rv_c), .init_busy(busy_c));

  // Observation bundle: {init_busy, read_valid, read_data (zero-extended)}.
  function automatic logic [33:0] obs(input int i);
    case (i)
      0:       return {busy_a, rv_a, rd_a};
      1:       return {busy_b, rv_b, rd_b};
      default: return {busy_c, rv_c, 16'h0, rd_c};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expd);
    total++;
    if (act === expd) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, expd);
  endtask

  typedef struct {
    int          inst;
    bit          w;
    logic [7:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  ben;
    bit          r;
    logic [7:0]  raddr;
    logic [31:0] expd;
    string       name;
  } vec_t;

  function automatic vec_t mk(input int inst, input bit w, input int a_w, input logic [31:0] d,
                              input logic [3:0] b, input bit r, input int a_r,
                              input logic [31:0] e, input string n);
    vec_t v;
    v.inst = inst; v.w = w; v.waddr = 8'(a_w); v.wdata = d; v.ben = b;
    v.r = r; v.raddr = 8'(a_r); v.expd = e; v.name = n;
    return v;
  endfunction

  task automatic idle_all();
    for (int i = 0; i < 3; i++) begin
      we[i] = 1'b0; wa[i] = '0; wd[i] = '0; be[i] = '0; re[i] = 1'b0; ra[i] = '0;
    end
  endtask

  // Drive one transaction for one cycle. If it contains a read, check the
  // latency, the data, the one-cycle pulse and the hold afterwards.
  task automatic apply(input vec_t v);
    logic [33:0] o;
    $display("txn %-12s inst=%0d we=%0b wa=%0d wd=%h be=%b re=%0b ra=%0d exp=%h",
             v.name, v.inst, v.w, v.waddr, v.wdata, v.ben, v.r, v.raddr, v.expd);
    we[v.inst] = v.w; wa[v.inst] = v.waddr; wd[v.inst] = v.wdata; be[v.inst] = v.ben;
    re[v.inst] = v.r; ra[v.inst] = v.raddr;
    @(posedge clk); #1;
    we[v.inst] = 1'b0; re[v.inst] = 1'b0;
    if (v.r) begin
      o = obs(v.inst);
      if (lat[v.inst] == 2) begin
        check({v.name, " early"}, 32'(o[32]), 32'd0);
        @(posedge clk); #1;
        o = obs(v.inst);
      end
      check({v.name, " valid"}, 32'(o[32]), 32'd1);
      check({v.name, " data"}, o[31:0], v.expd);
      @(posedge clk); #1;
      o = obs(v.inst);
      check({v.name, " pulse"}, 32'(o[32]), 32'd0);
      check({v.name, " hold"}, o[31:0], v.expd);
    end
  endtask

  vec_t        tbl[$];
  logic [33:0] o;
  int          fall [3];
  bit          seen_v;
  int          vidx[$];
  logic [31:0] vdat[$];
  int          s_addr [4] = '{3, 5, 1, 7};
  logic [31:0] s_exp  [4] = '{32'h11BB33DD, 32'h0000FFFF, 32'hA5A5A5A5, 32'hDEA5A5A5};

  initial begin
    // Every read in the A sweep-verify loop expects INIT_VALUE.
    for (int a = 0; a < 16; a++) tbl.push_back(mk(0, 0, 0, 0, 0, 1, a, 32'hA5A5A5A5, $sformatf("A_init%0d", a)));
    tbl.push_back(mk(0, 1, 3, 32'h11223344, 4'b1111, 0, 0, 0, "A_wr3_full"));
    tbl.push_back(mk(0, 1, 3, 32'hAABBCCDD, 4'b0101, 0, 0, 0, "A_wr3_be5"));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 3, 32'h11BB33DD, "A_rd3"));
    tbl.push_back(mk(0, 1, 5, 32'h00000000, 4'b1111, 0, 0, 0, "A_wr5_zero"));
    tbl.push_back(mk(0, 1, 5, 32'hFFFFFFFF, 4'b0011, 1, 5, 32'h0000FFFF, "A_coll_fwd"));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 5, 32'h0000FFFF, "A_rd5"));
    tbl.push_back(mk(0, 1, 7, 32'h12345678, 4'b0000, 0, 0, 0, "A_wr7_nobe"));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 7, 32'hA5A5A5A5, "A_rd7_nop"));
    tbl.push_back(mk(0, 1, 7, 32'hDEADBEEF, 4'b1000, 0, 0, 0, "A_wr7_be8"));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 7, 32'hDEA5A5A5, "A_rd7"));
    tbl.push_back(mk(1, 1, 3, 32'h11223344, 4'b1111, 0, 0, 0, "B_wr3_full"));
    tbl.push_back(mk(1, 1, 3, 32'hAABBCCDD, 4'b0101, 0, 0, 0, "B_wr3_be5"));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 3, 32'h11BB33DD, "B_rd3"));
    tbl.push_back(mk(1, 1, 5, 32'hFFFFFFFF, 4'b0011, 1, 5, 32'h00000000, "B_coll_rbw"));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 5, 32'h0000FFFF, "B_rd5"));
    tbl.push_back(mk(2, 0, 0, 0, 0, 1, 255, 32'h0000, "C_rd255_clr"));
    tbl.push_back(mk(2, 1, 255, 32'h0000BEEF, 4'b0010, 0, 0, 0, "C_wr255_hi"));
    tbl.push_back(mk(2, 0, 0, 0, 0, 1, 255, 32'h0000BE00, "C_rd255"));
    tbl.push_back(mk(2, 0, 0, 0, 0, 1, 0, 32'h0000, "C_rd0"));

    // ---------------- reset state ----------------
    idle_all();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      o = obs(i);
      check($sformatf("rst_busy%0d", i), 32'(o[33]), 32'd1);
      check($sformatf("rst_valid%0d", i), 32'(o[32]), 32'd0);
      check($sformatf("rst_data%0d", i), o[31:0], 32'd0);
    end

    // ---------------- clear sweep ----------------
    // Reads are requested during the sweep. They must produce no valid.
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) re[i] = 1'b1;
    fall = '{0, 0, 0};
    seen_v = 1'b0;
    for (int cyc = 1; cyc <= 400 && (fall[0] == 0 || fall[1] == 0 || fall[2] == 0); cyc++) begin
      @(posedge clk); #1;
      if (cyc == 10) for (int i = 0; i < 3; i++) re[i] = 1'b0;
      for (int i = 0; i < 3; i++) begin
        o = obs(i);
        if (o[32]) seen_v = 1'b1;
        if (fall[i] == 0 && !o[33]) fall[i] = cyc;
      end
    end
    check("sweep_len_A", 32'(fall[0]), 32'd16);
    check("sweep_len_B", 32'(fall[1]), 32'd16);
    check("sweep_len_C", 32'(fall[2]), 32'd256);
    check("sweep_no_valid", 32'(seen_v), 32'd0);
    check("sweep_rd_data_A", obs(0) & 34'h0FFFFFFFF, 32'd0);

    // ---------------- table-driven vectors ----------------
    foreach (tbl[k]) apply(tbl[k]);

    // ---------------- streaming reads on A (latency 2) ----------------
    // Addr 1 is read at step 2 and written at step 3, one cycle after
    // capture. Its result must still be the old value.
    for (int s = 0; s < 8; s++) begin
      if (s < 4) begin re[0] = 1'b1; ra[0] = 8'(s_addr[s]); end else re[0] = 1'b0;
      if (s == 3) begin we[0] = 1'b1; wa[0] = 8'd1; wd[0] = 32'h99999999; be[0] = 4'hF; end
      else we[0] = 1'b0;
      @(posedge clk); #1;
      o = obs(0);
      if (o[32]) begin vidx.push_back(s); vdat.push_back(o[31:0]); end
    end
    $display("txn stream A reads 3,5,1,7 -> %0d results", vidx.size());
    check("stream_count", 32'(vidx.size()), 32'd4);
    for (int k = 0; k < 4 && k < vidx.size(); k++) begin
      check($sformatf("stream_slot%0d", k), 32'(vidx[k]), 32'(k + 1));
      check($sformatf("stream_data%0d", k), vdat[k], s_exp[k]);
    end
    apply(mk(0, 0, 0, 0, 0, 1, 1, 32'h99999999, "A_rd1_late"));

    // ---------------- reset drops in-flight read ----------------
    $display("txn inflight read A addr 3 then reset");
    re[0] = 1'b1; ra[0] = 8'd3;
    @(posedge clk); #1;
    re[0] = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("drop_valid1", 32'(obs(0) >> 32) & 32'd1, 32'd0);
    @(posedge clk); #1;
    check("drop_valid2", 32'(obs(0) >> 32) & 32'd1, 32'd0);

    // ---------------- mid-sweep reset ----------------
    rst_n = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_busy", 32'(obs(0) >> 33), 32'd1);
    $display("txn restart sweep with user write A addr 2 = 0 pending");
    rst_n = 1'b1;
    we[0] = 1'b1; wa[0] = 8'd2; wd[0] = 32'h0; be[0] = 4'hF;
    re[0] = 1'b1; ra[0] = 8'd2;
    fall[0] = 0;
    seen_v = 1'b0;
    for (int cyc = 1; cyc <= 100 && fall[0] == 0; cyc++) begin
      @(posedge clk); #1;
      o = obs(0);
      if (o[32]) seen_v = 1'b1;
      if (!o[33]) fall[0] = cyc;
    end
    we[0] = 1'b0; re[0] = 1'b0;
    check("midrst_len", 32'(fall[0]), 32'd16);
    check("midrst_no_valid", 32'(seen_v), 32'd0);
    apply(mk(0, 0, 0, 0, 0, 1, 2, 32'hA5A5A5A5, "A_rd2_swept"));
    apply(mk(0, 0, 0, 0, 0, 1, 3, 32'hA5A5A5A5, "A_rd3_swept"));
    apply(mk(1, 0, 0, 0, 0, 1, 5, 32'h00000000, "B_rd5_swept"));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
